// File: rtl/shift_serializer.sv
// LSB-first parallel-to-serial transmitter with a valid/ready word input.
// Bits go out one per clock with s_en as the receiver's shift enable; GAP adds idle cycles between words.
module shift_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             s_out,
    output logic             s_en,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit STREAM = (GAP == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    bitcnt_reg;
    logic [GW-1:0]    gapcnt_reg;
    logic             done_reg;

    logic last_bit;
    logic accept;

    assign last_bit = (state_reg == ST_SHIFT) && (bitcnt_reg == BIT_LAST);

    // Ready looks ahead into the final bit so a streaming word can follow without a bubble.
    assign d_ready = reset && ((state_reg == ST_IDLE) || (STREAM && last_bit));
    assign accept  = d_valid && d_ready;

    assign s_en  = (state_reg == ST_SHIFT);
    assign s_out = s_en && shreg_reg[0];
    assign busy  = (state_reg != ST_IDLE);
    assign done  = done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
            gapcnt_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_reg  <= d_in;
                        bitcnt_reg <= '0;
                        state_reg  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        done_reg <= 1'b1;
                        if (accept) begin
                            shreg_reg  <= d_in;
                            bitcnt_reg <= '0;
                        end else begin
                            shreg_reg <= {1'b0, shreg_reg[WIDTH-1:1]};
                            if (!STREAM) begin
                                gapcnt_reg <= '0;
                                state_reg  <= ST_GAP;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end else begin
                        shreg_reg  <= {1'b0, shreg_reg[WIDTH-1:1]};
                        bitcnt_reg <= bitcnt_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gapcnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gapcnt_reg <= gapcnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule
